// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and master ids for the firmware RAM arbiter
package ram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;
endpackage

// File: rtl/ram_arb_rr2.sv
// ram_arb_rr2: two-way round-robin picker, favours the master not served last on a tie
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);
    // pick the lone requester, or the one not served last when both ask
    always_comb begin
        gnt_valid = |req;
        gnt_id    = &req ? ~last : req[M_DMA];
    end
endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin share of the registered firmware RAM port between CPU and DMA
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          MEM_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_valid,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_ready,
    output logic [31:0]   m0_rdata,
    input  logic          m1_valid,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_ready,
    output logic [31:0]   m1_rdata,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic [3:0]    ram_wstrb,
    input  logic [31:0]   ram_rdata,
    output logic          bus_err,
    output logic          grant_id
);
    state_t      state, state_n;
    logic        last, rd_ok, ram_en_q, gnt_valid, gnt_id, in_rng;
    logic [1:0]  req;
    logic [31:0] sel_addr, sel_wdata, off, rdata_q;
    logic [3:0]  sel_wstrb;

    ram_arb_rr2 u_rr (.req(req), .last(last), .gnt_valid(gnt_valid), .gnt_id(gnt_id));

    // request masking (served master ignored in DONE), winner bus mux, range check, next state
    always_comb begin
        req       = state == IDLE ? {m1_valid, m0_valid} :
                    state == DONE ? {m1_valid, m0_valid} & (grant_id ? 2'b01 : 2'b10) : 2'b00;
        sel_addr  = gnt_id ? m1_addr  : m0_addr;
        sel_wdata = gnt_id ? m1_wdata : m0_wdata;
        sel_wstrb = gnt_id ? m1_wstrb : m0_wstrb;
        off       = sel_addr - BASE_ADDR;
        in_rng    = off < 32'(4 * MEM_WORDS);
        state_n   = state == ACCESS ? DONE : gnt_valid ? ACCESS : IDLE;
    end

    // launch a RAM access on every grant; the enable lives for the ACCESS cycle only
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            grant_id  <= 1'b0;
            ram_en_q  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wstrb <= '0;
            bus_err   <= 1'b0;
            rd_ok     <= 1'b0;
        end else begin
            state <= state_n;
            if (gnt_valid) begin
                last      <= gnt_id;
                grant_id  <= gnt_id;
                ram_en_q  <= in_rng;
                ram_addr  <= off[AW+1:2];
                ram_wdata <= sel_wdata;
                ram_wstrb <= in_rng ? sel_wstrb : 4'h0;
                rd_ok     <= in_rng && sel_wstrb == 4'h0;
                bus_err   <= bus_err | ~in_rng;
            end else begin
                ram_en_q  <= 1'b0;
                ram_wstrb <= 4'h0;
            end
        end
    end

    // ready/rdata steered to the granted master; reset masks an enable the RAM would sample this edge
    always_comb begin
        m0_ready = state == DONE && grant_id == M_CPU;
        m1_ready = state == DONE && grant_id == M_DMA;
        rdata_q  = rd_ok ? ram_rdata : 32'h0;
        m0_rdata = m0_ready ? rdata_q : 32'h0;
        m1_rdata = m1_ready ? rdata_q : 32'h0;
        ram_en   = ram_en_q & ~reset;
    end
endmodule
